// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory block.
package prog_mem_pkg;

   // Controller states: CLEAR wipes the array after reset, IDLE serves fetches,
   // LOAD accepts program words from the loader.
   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      LOAD  = 2'd2
   } state_t;

   // NOP encoding is all zeros; sliced down to the instruction width at use.
   localparam logic [63:0] NOP = '0;

endpackage

// File: rtl/prog_mem_if.sv
// Fetch and load bus of the program memory, plus a debug view of the FSM state.
//
// Handshake: the loader offers a word with ld_valid/ld_data/ld_last; the word
// is transferred on a rising edge where ld_valid & ld_ready are both 1.
// ld_ready is 1 only while loading. Fetches are request/response: the
// requester holds fetch_req (with pc) until it observes the instr_valid pulse.
interface prog_mem_if
   import prog_mem_pkg::*;
   #(
      parameter int IW  = 8,
      parameter int AW  = 5,
      parameter int PCW = 8
   );

   logic           fetch_req;
   logic [PCW-1:0] pc;
   logic [IW-1:0]  instr;
   logic           instr_valid;
   logic           addr_fault;
   logic           ld_start;
   logic           ld_valid;
   logic [IW-1:0]  ld_data;
   logic           ld_last;
   logic           ld_ready;
   logic [AW:0]    ld_count;
   logic           busy;
   state_t         state;

   modport master (
      output fetch_req, pc, ld_start, ld_valid, ld_data, ld_last,
      input  instr, instr_valid, addr_fault, ld_ready, ld_count, busy, state
   );

   modport slave (
      input  fetch_req, pc, ld_start, ld_valid, ld_data, ld_last,
      output instr, instr_valid, addr_fault, ld_ready, ld_count, busy, state
   );

endinterface

// File: rtl/prog_mem_array.sv
// Storage array: one synchronous write port, one registered read port.
module prog_mem_array #(
   parameter int IW = 8,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   logic [IW-1:0] mem [2**AW];

   // Write port: one word per cycle when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port: registered, so data appears the cycle after the address.
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/prog_mem.sv
// Program memory controller: clears the array after reset, serves fetches
// with one-cycle latency and accepts program loads starting at address 0.
module prog_mem
   import prog_mem_pkg::*;
   #(
      parameter int IW  = 8,
      parameter int AW  = 5,
      parameter int PCW = 8
   ) (
      input  logic         clk,
      input  logic         rst,
      prog_mem_if.slave    bus
   );

   localparam int             DEPTH     = 2**AW;
   localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
   // One extra bit so the comparison still works when PCW == AW.
   localparam logic [PCW:0]   DEPTH_EXT = (PCW+1)'(DEPTH);

   state_t         state_q, state_d;
   logic [AW-1:0]  clr_ptr_q, clr_ptr_d;
   logic [AW-1:0]  ld_ptr_q, ld_ptr_d;
   logic [AW:0]    ld_count_q, ld_count_d;
   logic           valid_q, valid_d;
   logic           fault_q, fault_d;

   logic           we;
   logic [AW-1:0]  waddr;
   logic [IW-1:0]  wdata;
   logic [AW-1:0]  raddr;
   logic [IW-1:0]  rdata;

   prog_mem_array #(.IW(IW), .AW(AW)) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   // Next-state, pointer and write-port control.
   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      ld_ptr_d   = ld_ptr_q;
      ld_count_d = ld_count_q;
      valid_d    = 1'b0;
      fault_d    = 1'b0;
      we         = 1'b0;
      waddr      = clr_ptr_q;
      wdata      = NOP[IW-1:0];
      raddr      = bus.pc[AW-1:0];
      case (state_q)
         CLEAR: begin
            // One NOP per cycle; ld_start and fetch_req are ignored here.
            we        = 1'b1;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_ADDR) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            // A fetch coinciding with ld_start still reads the old contents.
            if (bus.fetch_req) begin
               valid_d = 1'b1;
               fault_d = ({1'b0, bus.pc} >= DEPTH_EXT);
            end
            if (bus.ld_start) begin
               state_d    = LOAD;
               ld_ptr_d   = '0;
               ld_count_d = '0;
            end
         end
         LOAD: begin
            if (bus.ld_start) begin
               // Restart wins over a same-cycle transfer; written words stay.
               ld_ptr_d   = '0;
               ld_count_d = '0;
            end else if (bus.ld_valid) begin
               we         = 1'b1;
               waddr      = ld_ptr_q;
               wdata      = bus.ld_data;
               ld_ptr_d   = ld_ptr_q + 1'b1;
               ld_count_d = ld_count_q + 1'b1;
               if (bus.ld_last || (ld_ptr_q == LAST_ADDR)) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // State, pointers and fetch-response flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_ptr_q  <= '0;
         ld_ptr_q   <= '0;
         ld_count_q <= '0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         ld_ptr_q   <= ld_ptr_d;
         ld_count_q <= ld_count_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
      end
   end

   // Outputs are forced to their reset values while rst is high so an
   // in-flight fetch never produces a pulse.
   assign bus.instr_valid = valid_q & ~rst;
   assign bus.addr_fault  = fault_q & ~rst;
   assign bus.instr       = (valid_q & ~fault_q & ~rst) ? rdata : NOP[IW-1:0];
   assign bus.ld_ready    = (state_q == LOAD) & ~rst;
   assign bus.ld_count    = ld_count_q;
   assign bus.busy        = (state_q != IDLE) | rst;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: reference model plus directed scenarios.
module tb_prog_mem;
   import prog_mem_pkg::*;

   localparam int IW    = 8;
   localparam int AW    = 5;
   localparam int PCW   = 8;
   localparam int DEPTH = 32;

   typedef logic [IW-1:0] word_q_t[$];

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prog_mem_if #(.IW(IW), .AW(AW), .PCW(PCW)) bus ();

   prog_mem #(.IW(IW), .AW(AW), .PCW(PCW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Memory as an array, clear as a countdown of remaining wipe cycles,
   // load as a flag with a write index; fetch results go into exp_q.
   logic [IW-1:0] m_mem [DEPTH];
   logic [IW:0]   exp_q[$];
   int            clear_left = 0;
   bit            loading    = 1'b0;
   int            wptr       = 0;
   int            cnt        = 0;
   bit            m_valid    = 1'b0;
   bit            model_on   = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         clear_left = DEPTH;
         loading    = 1'b0;
         wptr       = 0;
         cnt        = 0;
         m_valid    = 1'b0;
         exp_q.delete();
         model_on   = 1'b1;
      end else if (model_on) begin
         m_valid = 1'b0;
         if (clear_left > 0) begin
            m_mem[DEPTH - clear_left] = '0;
            clear_left--;
         end else if (loading) begin
            if (bus.ld_start) begin
               wptr = 0;
               cnt  = 0;
            end else if (bus.ld_valid) begin
               m_mem[wptr] = bus.ld_data;
               wptr++;
               cnt++;
               if (bus.ld_last || wptr == DEPTH) loading = 1'b0;
            end
         end else begin
            if (bus.fetch_req) begin
               m_valid = 1'b1;
               if (int'(bus.pc) >= DEPTH) exp_q.push_back({1'b1, {IW{1'b0}}});
               else exp_q.push_back({1'b0, m_mem[bus.pc[AW-1:0]]});
            end
            if (bus.ld_start) begin
               loading = 1'b1;
               wptr    = 0;
               cnt     = 0;
            end
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic [IW:0] e;
      if (model_on) begin
         if (rst) begin
            chk("rst_instr_valid", bus.instr_valid, 0);
            chk("rst_busy", bus.busy, 1);
            chk("rst_ld_ready", bus.ld_ready, 0);
            chk("rst_instr", bus.instr, 0);
            chk("rst_addr_fault", bus.addr_fault, 0);
         end else begin
            chk("instr_valid", bus.instr_valid, m_valid);
            chk("busy", bus.busy, (clear_left > 0) || loading);
            chk("ld_ready", bus.ld_ready, loading);
            chk("ld_count", bus.ld_count, cnt);
            if (m_valid && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("instr", bus.instr, e[IW-1:0]);
               chk("addr_fault", bus.addr_fault, e[IW]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic transfer(input logic [IW-1:0] d, input bit last);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
      step();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
   endtask

   task automatic load(input word_q_t w, input bit with_last);
      bus.ld_start = 1'b1;
      step();
      bus.ld_start = 1'b0;
      foreach (w[i]) transfer(w[i], with_last && (i == w.size() - 1));
   endtask

   task automatic wait_idle(input string name);
      int c = 0;
      while (bus.busy && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk(name, (c < 200), 1);
   endtask

   // ---------------- directed stimulus ----------------
   logic [IW-1:0] w6[$]  = '{8'h32, 8'h71, 8'h16, 8'hC1, 8'h53, 8'h22};
   logic [IW-1:0] w32[$];
   logic [IW-1:0] got;
   int busy_cnt, idle_at, valid_at;

   initial begin
      rst          = 1'b1;
      bus.fetch_req = 1'b0;
      bus.pc       = '0;
      bus.ld_start = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      bus.ld_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Clear lasts 32 busy cycles; a held fetch of pc=0 returns NOP after it.
      rst = 1'b0;
      bus.fetch_req = 1'b1;
      bus.pc = 8'd0;
      busy_cnt = 0; idle_at = -1; valid_at = -1; got = 8'hFF;
      for (int c = 0; c < 100 && valid_at < 0; c++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         else if (idle_at < 0) idle_at = c;
         if (bus.instr_valid) begin
            valid_at = c;
            got = bus.instr;
         end
      end
      bus.fetch_req = 1'b0;
      chk("clear_busy_cycles", busy_cnt, 32);
      chk("first_valid_seen", (valid_at >= 0), 1);
      chk("first_valid_latency", valid_at - idle_at, 1);
      chk("first_instr_nop", got, 8'h00);

      // Six-word load, then back-to-back fetch of 0..5.
      load(w6, 1'b1);
      @(negedge clk);
      chk("ld_count_6", bus.ld_count, 6);
      chk("idle_after_6", bus.busy, 0);
      bus.fetch_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.pc = PCW'(i);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("fetch6_pc%0d", i), bus.instr, w6[i]);
      end
      bus.fetch_req = 1'b0;

      // Out-of-range fetch.
      bus.fetch_req = 1'b1;
      bus.pc = 8'd40;
      @(posedge clk);
      @(negedge clk);
      chk("oor_valid", bus.instr_valid, 1);
      chk("oor_fault", bus.addr_fault, 1);
      chk("oor_instr", bus.instr, 8'h00);
      bus.fetch_req = 1'b0;

      // Full 32-word load without ld_last.
      for (int i = 0; i < DEPTH; i++) w32.push_back(IW'(i * 29 + 5));
      load(w32, 1'b0);
      @(negedge clk);
      chk("ld_count_32", bus.ld_count, 32);
      chk("ld_ready_after_full", bus.ld_ready, 0);
      bus.fetch_req = 1'b1;
      bus.pc = 8'd31;
      @(posedge clk);
      @(negedge clk);
      chk("fetch32_pc31", bus.instr, 8'h88);
      bus.fetch_req = 1'b0;

      // Fetch together with ld_start reads old word, then LOAD.
      @(posedge clk);
      #1;
      bus.fetch_req = 1'b1;
      bus.pc = 8'd1;
      bus.ld_start = 1'b1;
      step();
      bus.fetch_req = 1'b0;
      bus.ld_start = 1'b0;
      @(negedge clk);
      chk("fetch_with_start", bus.instr, 8'h22);
      chk("load_ready_after_start", bus.ld_ready, 1);
      step();
      // Three words, restart with a discarded same-cycle word, then two.
      transfer(8'hA1, 1'b0);
      transfer(8'hA2, 1'b0);
      transfer(8'hA3, 1'b0);
      bus.ld_start = 1'b1;
      transfer(8'hEE, 1'b0);
      bus.ld_start = 1'b0;
      transfer(8'hB1, 1'b0);
      transfer(8'hB2, 1'b1);
      @(negedge clk);
      chk("ld_count_restart", bus.ld_count, 2);
      bus.fetch_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.pc = PCW'(i);
         @(posedge clk);
         @(negedge clk);
         case (i)
            0: chk("restart_pc0", bus.instr, 8'hB1);
            1: chk("restart_pc1", bus.instr, 8'hB2);
            2: chk("restart_pc2", bus.instr, 8'hA3);
            default: chk("restart_pc3", bus.instr, 8'h5C);
         endcase
      end
      bus.fetch_req = 1'b0;

      // Reset mid-load after four words; clear must wipe everything.
      @(posedge clk);
      #1;
      bus.ld_start = 1'b1;
      step();
      bus.ld_start = 1'b0;
      transfer(8'hC1, 1'b0);
      transfer(8'hC2, 1'b0);
      transfer(8'hC3, 1'b0);
      transfer(8'hC4, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("ld_count_after_rst", bus.ld_count, 0);
      // ld_start during clear is ignored; a held fetch is dropped until idle.
      repeat (5) step();
      bus.ld_start = 1'b1;
      step();
      bus.ld_start = 1'b0;
      bus.fetch_req = 1'b1;
      bus.pc = 8'd5;
      wait_idle("clear_after_rst_done");
      for (int i = 0; i < DEPTH; i++) begin
         bus.pc = PCW'(i);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("cleared_pc%0d", i), bus.instr, 8'h00);
      end
      bus.fetch_req = 1'b0;

      // Fetch in flight when rst asserts produces no pulse.
      @(posedge clk);
      #1;
      bus.fetch_req = 1'b1;
      bus.pc = 8'd2;
      step();
      bus.fetch_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("inflight_lost", bus.instr_valid, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("no_pulse_after_rst", bus.instr_valid, 0);
      wait_idle("final_clear_done");
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter IW, default 8, instruction word width in bits.
REQ-002 Parameter AW, default 5, address width; DEPTH = 2**AW words (default 32).
REQ-003 Parameter PCW, default 8, program-counter width; PCW >= AW.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 fetch_req  in  1  fetch request; sampled only in state IDLE.
REQ-007 pc  in  PCW  fetch address, sampled with fetch_req.
REQ-008 instr  out  IW  fetched word, meaningful only while instr_valid=1.
REQ-009 instr_valid  out  1  one-cycle pulse, one per accepted fetch.
REQ-010 addr_fault  out  1  asserted with instr_valid when the sampled pc >= DEPTH.
REQ-011 ld_start  in  1  begin or restart a program load at address 0.
REQ-012 ld_valid  in  1  load word offered.
REQ-013 ld_data  in  IW  load word.
REQ-014 ld_last  in  1  qualifies the final load word; meaningful only with ld_valid.
REQ-015 ld_ready  out  1  1 only in state LOAD; a word transfers when ld_valid & ld_ready.
REQ-016 ld_count  out  AW+1  number of words written since the last ld_start.
REQ-017 busy  out  1  1 in states CLEAR and LOAD.

Function
REQ-018 Three states: CLEAR, IDLE, LOAD.
REQ-019 CLEAR: write NOP (all zeros) to address clr_ptr each cycle, clr_ptr counting 0..DEPTH-1; DEPTH cycles in total; after the write at DEPTH-1, go to IDLE.
REQ-020 IDLE: accept fetch_req; on ld_start, go to LOAD on the next cycle, with load pointer and ld_count cleared to 0.
REQ-021 Fetch latency: instr and instr_valid are registered; they appear exactly 1 cycle after fetch_req is sampled in IDLE; back-to-back fetches give one result per cycle.
REQ-022 Out-of-range pc (>= DEPTH): instr=0, addr_fault=1, instr_valid=1; no wrap-around.
REQ-023 fetch_req in CLEAR or LOAD is dropped (no instr_valid); the requester holds fetch_req until it sees instr_valid.
REQ-024 LOAD: each transfer writes ld_data to address ld_ptr, then increments ld_ptr and ld_count.
REQ-025 LOAD -> IDLE after a transfer with ld_last=1, or after the transfer at ld_ptr = DEPTH-1; in the IDLE cycle that follows, ld_count holds the final count (DEPTH when full).
REQ-026 ld_start in LOAD: restart; ld_ptr and ld_count return to 0; a transfer in the same cycle is discarded; already-written words are kept.
REQ-027 ld_start and fetch_req together in IDLE: the fetch is serviced from the old contents; LOAD starts the next cycle.
REQ-028 ld_start in CLEAR is ignored.
REQ-029 Memory contents persist across IDLE/LOAD transitions and change only through CLEAR or LOAD writes.

Reset
REQ-030 rst=1 at any clock edge, mid-load or mid-clear included, enters CLEAR with clr_ptr=0, ld_ptr=0, ld_count=0.
REQ-031 Output values during and directly after reset: instr=0, instr_valid=0, addr_fault=0, ld_ready=0, busy=1.
REQ-032 Any fetch in flight when rst asserts is lost; no instr_valid pulse follows.

Structure
REQ-033 Package prog_mem_pkg holds the state enumeration and the NOP constant (all zeros, IW bits).
REQ-034 Storage is a separate sub-module, prog_mem_array: one synchronous write port, one registered read port, parametrised by IW and AW.
REQ-035 The FSM, pointers and handshake logic live in prog_mem.

Verification
REQ-036 Reset, then hold fetch_req with pc=0 -> busy=1 for 32 cycles; first instr_valid 1 cycle after IDLE is reached, with instr=8'h00.
REQ-037 Load 6 words 8'h32, 8'h71, 8'h16, 8'hC1, 8'h53, 8'h22 (ld_last on the 6th), then fetch pc=0..5 back-to-back -> same words, one per cycle; ld_count=6.
REQ-038 Fetch pc=8'd40 -> instr=0, addr_fault=1, instr_valid=1.
REQ-039 Load 32 words without ld_last -> LOAD exits after the 32nd transfer; ld_count=32; ld_ready=0 the next cycle.
REQ-040 ld_start after 3 transfers, then load 2 words with ld_last -> addresses 0-1 hold the new words, address 2 keeps the old word, ld_count=2.
REQ-041 Assert rst mid-load after 4 words -> CLEAR restarts; every address reads 0 afterwards.
